// File: rtl/alu_ctrl_pkg.sv
// ALUControl code constants shared by the ALU controller, the ALU and the HI/LO unit.
// Pure declarations: no latency, no backpressure.
package alu_ctrl_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] ALU_MULT  = 5'b00011;
    localparam logic [4:0] ALU_MULTU = 5'b00100;
    localparam logic [4:0] ALU_MUL   = 5'b10011;
    localparam logic [4:0] ALU_MADD  = 5'b10100;
    localparam logic [4:0] ALU_MSUB  = 5'b10101;
    localparam logic [4:0] ALU_MFHI  = 5'b10111;
    localparam logic [4:0] ALU_MFLO  = 5'b11000;
    localparam logic [4:0] ALU_MTHI  = 5'b11001;
    localparam logic [4:0] ALU_MTLO  = 5'b11010;

    localparam int MULT_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } hilo_state_t;

    function automatic logic is_iterative(input logic [4:0] code);
        logic r;
        case (code)
            ALU_MULT, ALU_MULTU, ALU_MUL, ALU_MADD, ALU_MSUB: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_signed_op(input logic [4:0] code);
        logic r;
        case (code)
            ALU_MULT, ALU_MUL, ALU_MADD, ALU_MSUB: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    // 0x80000000 maps to 2^31, which still fits an unsigned 32-bit word.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_mult_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply unit.
// Start is only honoured while Busy is low; the stall logic watches Busy/Done.
interface hilo_mult_unit_if;
    import alu_ctrl_pkg::*;

    logic             Start;
    logic [4:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, ALUControl, A, B,
        input  Busy, Done, Result, HI, LO
    );

    modport slave (
        input  Start, ALUControl, A, B,
        output Busy, Done, Result, HI, LO
    );

endinterface

// File: rtl/mult_core_u32.sv
// 32-step unsigned radix-2 shift-add multiplier; one step per cycle, product valid after step 31.
// No backpressure: the owner decides when to load and when to step.
module mult_core_u32 (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic [63:0] product,
    output logic        last
);

    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] prod_q;
    logic [5:0]  count_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
        end else if (load) begin
            mcand_q  <= {32'd0, mcand};
            mplier_q <= mplier;
            prod_q   <= '0;
            count_q  <= '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= {mcand_q[62:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[31:1]};
            count_q  <= count_q + 6'd1;
        end
    end

    assign product = prod_q;
    assign last    = step && (count_q == 6'd31);

endmodule

// File: rtl/hilo_mult_unit.sv
// HI/LO multiply/accumulate unit: iterative ops commit 33 cycles after Start, moves in one cycle.
// Start is ignored while Busy; Done pulses for one cycle per completed operation.
module hilo_mult_unit
    import alu_ctrl_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    hilo_mult_unit_if.slave bus
);

    hilo_state_t state_q, state_d;

    logic             load, step, commit, single, last;
    logic             sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [63:0]      product, prod_fix, acc;

    logic [4:0]       op_q;
    logic             neg_q;
    logic [WIDTH-1:0] hi_q, lo_q, result_q;
    logic             done_q;

    assign sgn   = is_signed_op(bus.ALUControl);
    assign a_mag = magnitude(bus.A, sgn);
    assign b_mag = magnitude(bus.B, sgn);

    mult_core_u32 u_core (
        .Clk     (Clk),
        .Rst     (Rst),
        .load    (load),
        .step    (step),
        .mcand   (a_mag),
        .mplier  (b_mag),
        .product (product),
        .last    (last)
    );

    assign prod_fix = neg_q ? (~product + 64'd1) : product;
    assign acc      = {hi_q, lo_q};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        single  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    if (is_iterative(bus.ALUControl)) begin
                        load    = 1'b1;
                        state_d = ST_CALC;
                    end else begin
                        single = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (last) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                op_q  <= bus.ALUControl;
                neg_q <= sgn && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            end
            if (single) begin
                done_q <= 1'b1;
                case (bus.ALUControl)
                    ALU_MTHI: hi_q     <= bus.A;
                    ALU_MTLO: lo_q     <= bus.A;
                    ALU_MFHI: result_q <= hi_q;
                    ALU_MFLO: result_q <= lo_q;
                    default:  result_q <= '0;
                endcase
            end
            if (commit) begin
                done_q <= 1'b1;
                case (op_q)
                    ALU_MULT, ALU_MULTU: {hi_q, lo_q} <= prod_fix;
                    ALU_MUL:             result_q     <= prod_fix[WIDTH-1:0];
                    ALU_MADD:            {hi_q, lo_q} <= acc + prod_fix;
                    ALU_MSUB:            {hi_q, lo_q} <= acc - prod_fix;
                    default:             ;
                endcase
            end
        end
    end

    assign bus.Busy   = (state_q != ST_IDLE);
    assign bus.Done   = done_q;
    assign bus.Result = result_q;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;

endmodule
